// File: rtl/vend_pkg.sv
// ============================================================================
// Module      : vend_pkg
// Description : Shared state, coin encodings and greedy change selection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam logic [3:0] VAL_1 = 4'd1;
  localparam logic [3:0] VAL_2 = 4'd2;
  localparam logic [3:0] VAL_5 = 4'd5;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return VAL_1;
      COIN_2:  return VAL_2;
      COIN_5:  return VAL_5;
      default: return 4'd0;
    endcase
  endfunction

  // Largest coin not exceeding the credit; COIN_NONE when nothing is owed.
  function automatic logic [1:0] greedy_coin(input logic [3:0] credit);
    if (credit >= VAL_5)      return COIN_5;
    else if (credit >= VAL_2) return COIN_2;
    else if (credit >= VAL_1) return COIN_1;
    else                      return COIN_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_decode.sv
// ============================================================================
// Module      : coin_decode
// Description : Converts a coin-slot code into its rupee value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_decode
  import vend_pkg::*;
(
  input  logic [1:0] i_coin,
  output logic [3:0] o_value
);

  assign o_value = coin_value(i_coin);

endmodule

`default_nettype wire

// File: rtl/vend_controller.sv
// ============================================================================
// Module      : vend_controller
// Description : Coin credit accumulation, purchase validation, greedy change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE      = 7,
  parameter int MAX_CREDIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       select,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic       dispense,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [3:0] c_price = 4'(PRICE);
  localparam logic [4:0] c_max   = 5'(MAX_CREDIT);

  if (PRICE < 1 || PRICE > MAX_CREDIT || MAX_CREDIT > 15) begin : g_param_check
    $error("vend_controller: illegal PRICE/MAX_CREDIT combination");
  end

  state_t     r_state;
  logic [3:0] r_credit;
  logic       r_reject;

  logic [3:0] w_coin_val;
  logic [4:0] w_sum;
  logic [1:0] w_change_coin;
  logic [3:0] w_change_val;
  logic       w_coin_in;

  coin_decode u_coin_decode (
    .i_coin  (coin),
    .o_value (w_coin_val)
  );

  // Widened add so an overflowing coin is detected rather than wrapped.
  assign w_sum         = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_change_coin = greedy_coin(r_credit);
  assign w_change_val  = coin_value(w_change_coin);
  assign w_coin_in     = (coin != COIN_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= COLLECT;
      r_credit <= 4'd0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (cancel) begin
            if (r_credit != 4'd0) r_state <= CHANGE;
            r_reject <= w_coin_in;
          end else if (select) begin
            if (r_credit >= c_price) begin
              r_credit <= r_credit - c_price;
              r_state  <= DISPENSE;
            end
            r_reject <= w_coin_in;
          end else if (w_coin_in) begin
            if (w_sum <= c_max) r_credit <= w_sum[3:0];
            else                r_reject <= 1'b1;
          end
        end
        DISPENSE: begin
          r_state  <= (r_credit != 4'd0) ? CHANGE : COLLECT;
          r_reject <= w_coin_in;
        end
        CHANGE: begin
          r_credit <= r_credit - w_change_val;
          if (r_credit == w_change_val) r_state <= COLLECT;
          r_reject <= w_coin_in;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign credit       = r_credit;
  assign dispense     = (r_state == DISPENSE);
  assign change_valid = (r_state == CHANGE);
  assign change_coin  = (r_state == CHANGE) ? w_change_coin : COIN_NONE;
  assign coin_reject  = r_reject;
  assign busy         = (r_state != COLLECT);

endmodule

`default_nettype wire
